lc3_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the LC-3 core. It owns PC, IR, MDR and the NZP condition codes. It fetches over a single req/ready memory port, decodes BR/ADD/LD/ST/AND/NOT/HALT, and drives register-file and ALU control to an external datapath. It replaces single-cycle fetch-and-execute with an explicit FSM so memory wait states and load/store can be supported.

---
 rtl/lc3_ctrl_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_lc3_ctrl_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_ctrl_seq.sv
// LC-3 multi-cycle control sequencer: owns PC/IR/MDR/CC, fetches over a req/ready
// memory port and drives register-file/ALU control to an external datapath.
module lc3_ctrl_seq #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [15:0] i_mem_rdata,
    output logic [2:0]  o_rf_rd_addr1,
    output logic [2:0]  o_rf_rd_addr2,
    output logic [1:0]  o_alu_op,
    output logic        o_alu_use_imm,
    output logic [15:0] o_imm,
    output logic        o_rf_we,
    output logic [2:0]  o_rf_wr_addr,
    output logic        o_wb_sel,
    output logic [15:0] o_mdr,
    input  logic [15:0] i_wb_value,
    output logic [15:0] o_pc,
    output logic [2:0]  o_cc,
    output logic        o_retire,
    output logic        o_illegal,
    output logic        o_halted
);
    localparam int unsigned W = 16;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    logic [2:0]   state, state_n;
    logic [W-1:0] pc, pc_n, ir, ir_n, mdr, mdr_n, addr, addr_n, imm, imm_n;
    logic [2:0]   cc, cc_n, rd1, rd1_n, rd2, rd2_n, wr, wr_n;
    logic [1:0]   alu_op, alu_op_n;
    logic         use_imm, use_imm_n, wb_sel, wb_sel_n;
    logic         req, req_n, we, we_n, rf_we, rf_we_n;
    logic         retire_q, retire_n, illegal, illegal_n, halted, halted_n;

    logic [3:0]   op;
    logic [W-1:0] off9;
    logic [1:0]   alu_dec;
    logic         taken, known_op, mem_done, st_done;

    assign op       = ir[15:12];
    assign off9     = {{7{ir[8]}}, ir[8:0]};
    assign taken    = (ir[11] & cc[0]) | (ir[10] & cc[1]) | (ir[9] & cc[2]);
    assign known_op = (op == OP_BR) | (op == OP_ADD) | (op == OP_LD) | (op == OP_ST) |
                      (op == OP_AND) | (op == OP_NOT) | (op == OP_HALT);
    assign alu_dec  = (op == OP_ADD) ? ALU_ADD :
                      (op == OP_AND) ? ALU_AND :
                      (op == OP_NOT) ? ALU_NOT : ALU_PASS;
    assign mem_done = req & i_mem_ready;
    // A store completes in its MEM handshake cycle, so its retire cannot wait a clock.
    assign st_done  = (state == S_MEM) & we & i_mem_ready;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        mdr_n     = mdr;
        cc_n      = cc;
        addr_n    = addr;
        rd1_n     = rd1;
        rd2_n     = rd2;
        wr_n      = wr;
        imm_n     = imm;
        alu_op_n  = alu_op;
        use_imm_n = use_imm;
        wb_sel_n  = wb_sel;
        retire_n  = 1'b0;
        illegal_n = 1'b0;

        case (state)
            S_FETCH: begin
                if (mem_done) begin
                    ir_n    = i_mem_rdata;
                    pc_n    = pc + W'(1);
                    state_n = S_DECODE;
                end else begin
                    addr_n  = pc;
                end
            end
            S_DECODE: begin
                state_n   = S_EXEC;
                rd1_n     = (op == OP_ST) ? ir[11:9] : ir[8:6];
                rd2_n     = ir[2:0];
                wr_n      = ir[11:9];
                imm_n     = {{11{ir[4]}}, ir[4:0]};
                use_imm_n = ((op == OP_ADD) || (op == OP_AND)) && ir[5];
                alu_op_n  = alu_dec;
                wb_sel_n  = (op == OP_LD);
                retire_n  = (op == OP_BR) || (op == OP_HALT);
                illegal_n = !known_op;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: state_n = S_WB;
                    OP_BR: begin
                        pc_n    = taken ? pc + off9 : pc;
                        addr_n  = pc_n;
                        state_n = S_FETCH;
                    end
                    OP_LD, OP_ST: begin
                        addr_n  = pc + off9;
                        state_n = S_MEM;
                    end
                    OP_HALT: state_n = S_HALT;
                    default: begin
                        addr_n  = pc;
                        state_n = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_done) begin
                    addr_n = pc;
                    if (op == OP_ST) begin
                        state_n = S_FETCH;
                    end else begin
                        mdr_n   = i_mem_rdata;
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                if (i_wb_value[15])           cc_n = 3'b001;
                else if (i_wb_value == '0)    cc_n = 3'b010;
                else                          cc_n = 3'b100;
                addr_n  = pc;
                state_n = S_FETCH;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase

        req_n    = (state_n == S_FETCH) || (state_n == S_MEM);
        we_n     = (state_n == S_MEM) && (op == OP_ST);
        rf_we_n  = (state_n == S_WB);
        retire_n = retire_n || (state_n == S_WB);
        halted_n = (state_n == S_HALT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            ir       <= '0;
            mdr      <= '0;
            cc       <= 3'b010;
            addr     <= '0;
            rd1      <= '0;
            rd2      <= '0;
            wr       <= '0;
            imm      <= '0;
            alu_op   <= '0;
            use_imm  <= 1'b0;
            wb_sel   <= 1'b0;
            req      <= 1'b0;
            we       <= 1'b0;
            rf_we    <= 1'b0;
            retire_q <= 1'b0;
            illegal  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            mdr      <= mdr_n;
            cc       <= cc_n;
            addr     <= addr_n;
            rd1      <= rd1_n;
            rd2      <= rd2_n;
            wr       <= wr_n;
            imm      <= imm_n;
            alu_op   <= alu_op_n;
            use_imm  <= use_imm_n;
            wb_sel   <= wb_sel_n;
            req      <= req_n;
            we       <= we_n;
            rf_we    <= rf_we_n;
            retire_q <= retire_n;
            illegal  <= illegal_n;
            halted   <= halted_n;
        end
    end

    assign o_mem_req     = req;
    assign o_mem_we      = we;
    assign o_mem_addr    = addr;
    assign o_rf_rd_addr1 = rd1;
    assign o_rf_rd_addr2 = rd2;
    assign o_alu_op      = alu_op;
    assign o_alu_use_imm = use_imm;
    assign o_imm         = imm;
    assign o_rf_we       = rf_we;
    assign o_rf_wr_addr  = wr;
    assign o_wb_sel      = wb_sel;
    assign o_mdr         = mdr;
    assign o_pc          = pc;
    assign o_cc          = cc;
    assign o_retire      = retire_q | st_done;
    assign o_illegal     = illegal;
    assign o_halted      = halted;

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Bench for lc3_ctrl_seq: a memory responder with programmable wait states and a
// queue of expected memory accesses that each handshake is checked against.
module tb_lc3_ctrl_seq;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_mem_req, o_mem_we, i_mem_ready;
    logic [15:0] o_mem_addr, i_mem_rdata;
    logic [2:0]  o_rf_rd_addr1, o_rf_rd_addr2, o_rf_wr_addr, o_cc;
    logic [1:0]  o_alu_op;
    logic        o_alu_use_imm, o_rf_we, o_wb_sel, o_retire, o_illegal, o_halted;
    logic [15:0] o_imm, o_mdr, i_wb_value, o_pc;

    always #5 clk = ~clk;

    lc3_ctrl_seq #(.PC_RESET(16'h0000)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
        .o_rf_rd_addr1(o_rf_rd_addr1), .o_rf_rd_addr2(o_rf_rd_addr2),
        .o_alu_op(o_alu_op), .o_alu_use_imm(o_alu_use_imm), .o_imm(o_imm),
        .o_rf_we(o_rf_we), .o_rf_wr_addr(o_rf_wr_addr), .o_wb_sel(o_wb_sel),
        .o_mdr(o_mdr), .i_wb_value(i_wb_value), .o_pc(o_pc), .o_cc(o_cc),
        .o_retire(o_retire), .o_illegal(o_illegal), .o_halted(o_halted)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        fetch;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] mem [logic [15:0]];

    int checks = 0, failures = 0;
    int cyc = 0, wait_cfg = 0, wait_cnt = 0, req_begin = 0, fetch_start = 0;
    int lat = 0, rf_lat = 0, n_retire = 0, n_illegal = 0, n_rf_we = 0, n_req = 0;
    logic [2:0]  rf_wr, hs_rd1;
    logic        rf_sel;
    logic [15:0] rf_mdr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic expect_acc(input logic [15:0] a, input logic we, input logic f);
        acc_t e;
        e.addr  = a;
        e.we    = we;
        e.fetch = f;
        exp_q.push_back(e);
    endtask

    // One clock: drive memory response at negedge, then sample and score.
    task automatic tick();
        acc_t e;
        @(negedge clk);
        cyc++;
        if (o_mem_req) begin
            if (wait_cnt == 0) req_begin = cyc;
            i_mem_ready = (wait_cnt >= wait_cfg);
            i_mem_rdata = i_mem_ready ? mem_rd(o_mem_addr) : 16'hDEAD;
            wait_cnt    = i_mem_ready ? 0 : wait_cnt + 1;
        end else begin
            i_mem_ready = 1'b0;
            wait_cnt    = 0;
        end
        #1;
        if (o_mem_req) n_req++;
        if (o_mem_req && i_mem_ready) begin
            check_eq("acc_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("acc_addr", 32'(o_mem_addr), 32'(e.addr));
                check_eq("acc_we", 32'(o_mem_we), 32'(e.we));
                if (e.fetch) fetch_start = req_begin;
                else         hs_rd1 = o_rf_rd_addr1;
            end
        end
        if (o_retire) begin
            n_retire++;
            lat = cyc - fetch_start + 1;
        end
        if (o_rf_we) begin
            n_rf_we++;
            rf_lat = cyc - fetch_start + 1;
            rf_wr  = o_rf_wr_addr;
            rf_sel = o_wb_sel;
            rf_mdr = o_mdr;
        end
        if (o_illegal) n_illegal++;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        check_eq("rst_req_low", 32'(o_mem_req), 32'd0);
        tick();
        check_eq("rst_pc", 32'(o_pc), 32'h0000);
        check_eq("rst_cc", 32'(o_cc), 32'b010);
        check_eq("rst_strobes", 32'({o_mem_we, o_rf_we, o_retire, o_illegal, o_halted}), 32'd0);
        check_eq("rst_mdr_imm", 32'({o_mdr, o_imm}), 32'd0);
        mem.delete();
        exp_q.delete();
        n_retire = 0; n_illegal = 0; n_rf_we = 0; n_req = 0; lat = 0; rf_lat = 0;
        wait_cfg = 0;
        i_rst = 1'b0;
    endtask

    task automatic run_drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_mem_ready = 1'b0;
        i_mem_rdata = 16'h0000;
        i_wb_value  = 16'h0000;

        // ADD R1,R1,#-1 with a negative writeback
        do_reset();
        mem[16'h0000] = 16'h127F;
        i_wb_value = 16'hFFFF;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0001, 1'b0, 1'b1);
        run_drain(30);
        check_eq("add_rf_we_cycle", 32'(rf_lat), 32'd4);
        check_eq("add_latency", 32'(lat), 32'd4);
        check_eq("add_wr_addr", 32'(rf_wr), 32'd1);
        check_eq("add_wb_sel", 32'(rf_sel), 32'd0);
        check_eq("add_imm", 32'(o_imm), 32'hFFFF);
        check_eq("add_use_imm", 32'(o_alu_use_imm), 32'd1);
        check_eq("add_alu_op", 32'(o_alu_op), 32'd0);
        check_eq("add_rd_addrs", 32'({o_rf_rd_addr1, o_rf_rd_addr2}), 32'({3'd1, 3'd7}));
        check_eq("add_cc", 32'(o_cc), 32'b001);
        check_eq("add_pc", 32'(o_pc), 32'h0001);

        // BRz +3 taken with reset CC=Z
        do_reset();
        mem[16'h0000] = 16'h0E0F;
        mem[16'h0010] = 16'h0403;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0010, 1'b0, 1'b1);
        expect_acc(16'h0014, 1'b0, 1'b1);
        run_drain(30);
        check_eq("brz_latency", 32'(lat), 32'd3);
        check_eq("brz_cc", 32'(o_cc), 32'b010);

        // BRz +3 not taken after CC becomes P
        do_reset();
        i_wb_value = 16'h0005;
        mem[16'h0000] = 16'h127F;
        mem[16'h0001] = 16'h0E0E;
        mem[16'h0010] = 16'h0403;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0001, 1'b0, 1'b1);
        expect_acc(16'h0010, 1'b0, 1'b1);
        expect_acc(16'h0011, 1'b0, 1'b1);
        run_drain(40);
        check_eq("brp_cc", 32'(o_cc), 32'b100);
        check_eq("brp_retires", 32'(n_retire), 32'd3);

        // nzp=000 is never taken
        do_reset();
        mem[16'h0000] = 16'h0E0F;
        mem[16'h0010] = 16'h0003;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0010, 1'b0, 1'b1);
        expect_acc(16'h0011, 1'b0, 1'b1);
        run_drain(30);

        // BRnzp -2 from 0x0020
        do_reset();
        mem[16'h0000] = 16'h0E1F;
        mem[16'h0020] = 16'h0FFE;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0020, 1'b0, 1'b1);
        expect_acc(16'h001F, 1'b0, 1'b1);
        run_drain(30);

        // PC wrap through 0xFFFF
        do_reset();
        mem[16'h0000] = 16'h0FFE;
        mem[16'hFFFF] = 16'h0E00;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'hFFFF, 1'b0, 1'b1);
        expect_acc(16'h0000, 1'b0, 1'b1);
        run_drain(30);

        // LD R2,#+4 at 0x0100 with three wait cycles per access
        do_reset();
        wait_cfg   = 3;
        i_wb_value = 16'hBEEF;
        mem[16'h0000] = 16'h0EFF;
        mem[16'h0100] = 16'h2404;
        mem[16'h0105] = 16'hBEEF;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0100, 1'b0, 1'b1);
        expect_acc(16'h0105, 1'b0, 1'b0);
        expect_acc(16'h0101, 1'b0, 1'b1);
        run_drain(80);
        check_eq("ld_latency", 32'(lat), 32'd11);
        check_eq("ld_mdr", 32'(rf_mdr), 32'hBEEF);
        check_eq("ld_wb_sel", 32'(rf_sel), 32'd1);
        check_eq("ld_wr_addr", 32'(rf_wr), 32'd2);
        check_eq("ld_cc", 32'(o_cc), 32'b001);

        // ST R3,#-1 at 0x0200
        do_reset();
        mem[16'h0000] = 16'h0EFF;
        mem[16'h0100] = 16'h0EFF;
        mem[16'h0200] = 16'h37FF;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0100, 1'b0, 1'b1);
        expect_acc(16'h0200, 1'b0, 1'b1);
        expect_acc(16'h0200, 1'b1, 1'b0);
        expect_acc(16'h0201, 1'b0, 1'b1);
        run_drain(40);
        check_eq("st_latency", 32'(lat), 32'd4);
        check_eq("st_rd_addr1", 32'(hs_rd1), 32'd3);
        check_eq("st_no_rf_we", 32'(n_rf_we), 32'd0);
        check_eq("st_cc", 32'(o_cc), 32'b010);
        check_eq("st_retires", 32'(n_retire), 32'd3);

        // HALT absorbs and issues no further requests
        do_reset();
        mem[16'h0000] = 16'hF025;
        expect_acc(16'h0000, 1'b0, 1'b1);
        run_drain(10);
        n_req = 0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("halt_no_req", 32'(n_req), 32'd0);
        check_eq("halt_flag", 32'(o_halted), 32'd1);
        check_eq("halt_retires", 32'(n_retire), 32'd1);
        check_eq("halt_cc", 32'(o_cc), 32'b010);

        // Unsupported opcode 1101
        do_reset();
        mem[16'h0000] = 16'hD000;
        expect_acc(16'h0000, 1'b0, 1'b1);
        expect_acc(16'h0001, 1'b0, 1'b1);
        run_drain(30);
        check_eq("ill_pulse", 32'(n_illegal), 32'd1);
        check_eq("ill_no_retire", 32'(n_retire), 32'd0);
        check_eq("ill_pc", 32'(o_pc), 32'h0001);
        check_eq("ill_cc", 32'(o_cc), 32'b010);

        // Reset while a fetch waits on ready
        do_reset();
        wait_cfg = 5;
        for (int i = 0; i < 5 && !o_mem_req; i++) tick();
        check_eq("abort_req_up", 32'(o_mem_req), 32'd1);
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        check_eq("abort_req_low", 32'(o_mem_req), 32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 5 && !o_mem_req; i++) tick();
        check_eq("abort_refetch_req", 32'(o_mem_req), 32'd1);
        check_eq("abort_refetch_addr", 32'(o_mem_addr), 32'h0000);
        check_eq("abort_cc", 32'(o_cc), 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
